// File: rtl/fifo_rd_frame_ctrl.sv
// fifo_rd_frame_ctrl
// Read-domain controller for the audio-sample async FIFO. Owns the read pointer,
// derives empty from the synchronized Gray write pointer, and reads the FIFO RAM
// in fixed-length frames that leave on a valid/ready stream. A 2-entry skid
// buffer absorbs the one-cycle RAM latency so backpressure never drops a sample.
//
// Ports:
//   rclk, rrst_n  read clock, asynchronous active-low reset
//   rq2_wptr      Gray write pointer, already synchronized into rclk
//   rptr          registered Gray read pointer (to the write-side synchronizer)
//   raddr, ren    RAM read address / enable; rdata is valid one rclk after ren
//   rdata         RAM read data
//   rempty        registered FIFO empty
//   start, flush  frame start / discard-all pulses (honoured only when idle)
//   m_data, m_valid, m_ready, m_last  output sample stream
//   busy          frame in progress (RUN or DRAIN)
//   frame_done    one-cycle pulse after the last beat of a frame is accepted
module fifo_rd_frame_ctrl #(
  parameter int unsigned ASIZE     = 4,
  parameter int unsigned DSIZE     = 16,
  parameter int unsigned FRAME_LEN = 256
) (
  input  logic             rclk,
  input  logic             rrst_n,
  input  logic [ASIZE:0]   rq2_wptr,
  output logic [ASIZE:0]   rptr,
  output logic [ASIZE-1:0] raddr,
  output logic             ren,
  input  logic [DSIZE-1:0] rdata,
  output logic             rempty,
  input  logic             start,
  input  logic             flush,
  output logic [DSIZE-1:0] m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic             m_last,
  output logic             busy,
  output logic             frame_done
);

  localparam int unsigned   CW       = $clog2(FRAME_LEN + 1);
  localparam logic [CW-1:0] FrameLen = CW'(FRAME_LEN);
  localparam logic [CW-1:0] LastIdx  = CW'(FRAME_LEN - 1);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e           state_q, state_d;
  logic [ASIZE:0]   rbin_q, rbin_d, rbin_inc, rgray_next;
  logic [ASIZE:0]   rptr_q, rptr_d;
  logic             rempty_q, rempty_d;
  logic [CW-1:0]    issued_q, issued_d;
  logic             infl_q, infl_last_q;
  logic [1:0]       occ_q, occ_d;
  logic [DSIZE-1:0] buf0_data_q, buf0_data_d, buf1_data_q, buf1_data_d;
  logic             buf0_last_q, buf0_last_d, buf1_last_q, buf1_last_d;
  logic             frame_done_q, frame_done_d;
  logic             pop, do_flush;
  logic [2:0]       held_after;

  function automatic logic [ASIZE:0] gray2bin(input logic [ASIZE:0] g);
    logic [ASIZE:0] b;
    b[ASIZE] = g[ASIZE];
    for (int i = int'(ASIZE) - 1; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

  // Head of stream: skid buffer first, else bypass the in-flight RAM word.
  always_comb begin
    m_valid = (occ_q != 2'd0) || infl_q;
    m_data  = '0;
    m_last  = 1'b0;
    if (occ_q != 2'd0) begin
      m_data = buf0_data_q;
      m_last = buf0_last_q;
    end else if (infl_q) begin
      m_data = rdata;
      m_last = infl_last_q;
    end
  end

  assign pop      = m_valid && m_ready;
  assign do_flush = (state_q == StIdle) && flush;

  // Words held after this cycle's pop; a new read needs a free slot for next cycle.
  assign held_after = 3'(occ_q) + 3'(infl_q) - 3'(pop);

  assign ren = (state_q == StRun) && !rempty_q && (issued_q < FrameLen) && (held_after < 3'd2);

  // Read pointer and empty flag
  always_comb begin
    rbin_inc   = rbin_q + (ASIZE + 1)'(ren);
    rgray_next = (rbin_inc >> 1) ^ rbin_inc;
    if (do_flush) begin
      rbin_d   = gray2bin(rq2_wptr);
      rptr_d   = rq2_wptr;
      rempty_d = 1'b1;
    end else begin
      rbin_d   = rbin_inc;
      rptr_d   = rgray_next;
      rempty_d = (rgray_next == rq2_wptr);
    end
  end

  // Frame sequencer
  always_comb begin
    state_d      = state_q;
    issued_d     = issued_q;
    frame_done_d = 1'b0;
    unique case (state_q)
      StIdle: begin
        // flush wins over a simultaneous start
        if (start && !flush) begin
          state_d  = StRun;
          issued_d = '0;
        end
      end
      StRun: begin
        if (ren) begin
          issued_d = issued_q + CW'(1);
          if (issued_q == LastIdx) state_d = StDrain;
        end
      end
      StDrain: begin
        if (pop && m_last) begin
          state_d      = StIdle;
          frame_done_d = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Skid buffer: order is buf0, buf1, in-flight word; drop the head on pop.
  always_comb begin
    logic [DSIZE-1:0] e0_data, e1_data;
    logic             e0_last, e1_last;
    logic [1:0]       n;
    e0_data = buf0_data_q;
    e0_last = buf0_last_q;
    e1_data = buf1_data_q;
    e1_last = buf1_last_q;
    if (occ_q == 2'd0) begin
      e0_data = rdata;
      e0_last = infl_last_q;
    end else if (occ_q == 2'd1) begin
      e1_data = rdata;
      e1_last = infl_last_q;
    end
    n = occ_q + {1'b0, infl_q};
    buf1_data_d = buf1_data_q;
    buf1_last_d = buf1_last_q;
    if (pop) begin
      buf0_data_d = e1_data;
      buf0_last_d = e1_last;
      occ_d       = n - 2'd1;
    end else begin
      buf0_data_d = e0_data;
      buf0_last_d = e0_last;
      buf1_data_d = e1_data;
      buf1_last_d = e1_last;
      occ_d       = n;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      state_q      <= StIdle;
      rbin_q       <= '0;
      rptr_q       <= '0;
      rempty_q     <= 1'b1;
      issued_q     <= '0;
      infl_q       <= 1'b0;
      infl_last_q  <= 1'b0;
      occ_q        <= 2'd0;
      buf0_data_q  <= '0;
      buf0_last_q  <= 1'b0;
      buf1_data_q  <= '0;
      buf1_last_q  <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      rbin_q       <= rbin_d;
      rptr_q       <= rptr_d;
      rempty_q     <= rempty_d;
      issued_q     <= issued_d;
      infl_q       <= ren;
      infl_last_q  <= ren && (issued_q == LastIdx);
      occ_q        <= occ_d;
      buf0_data_q  <= buf0_data_d;
      buf0_last_q  <= buf0_last_d;
      buf1_data_q  <= buf1_data_d;
      buf1_last_q  <= buf1_last_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign rptr       = rptr_q;
  assign raddr      = rbin_q[ASIZE-1:0];
  assign rempty     = rempty_q;
  assign busy       = (state_q != StIdle);
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_fifo_rd_frame_ctrl.sv
// Self-checking bench for fifo_rd_frame_ctrl (ASIZE=4, DSIZE=16, FRAME_LEN=8).
// The FIFO is a sample queue; each frame must deliver the next FRAME_LEN queued
// samples in order with m_last on the final one.
module tb_fifo_rd_frame_ctrl;

  localparam int ASIZE = 4;
  localparam int DSIZE = 16;
  localparam int FL    = 8;

  logic             rclk = 1'b0;
  logic             rrst_n;
  logic [ASIZE:0]   rq2_wptr;
  logic [ASIZE:0]   rptr;
  logic [ASIZE-1:0] raddr;
  logic             ren;
  logic [DSIZE-1:0] rdata = '0;
  logic             rempty;
  logic             start, flush;
  logic [DSIZE-1:0] m_data;
  logic             m_valid, m_ready, m_last, busy, frame_done;

  fifo_rd_frame_ctrl #(
    .ASIZE    (ASIZE),
    .DSIZE    (DSIZE),
    .FRAME_LEN(FL)
  ) dut (
    .rclk      (rclk),
    .rrst_n    (rrst_n),
    .rq2_wptr  (rq2_wptr),
    .rptr      (rptr),
    .raddr     (raddr),
    .ren       (ren),
    .rdata     (rdata),
    .rempty    (rempty),
    .start     (start),
    .flush     (flush),
    .m_data    (m_data),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_last    (m_last),
    .busy      (busy),
    .frame_done(frame_done)
  );

  always #5 rclk = ~rclk;

  // FIFO RAM with one-cycle read latency
  logic [DSIZE-1:0] mem [16];
  always @(posedge rclk) if (ren) rdata <= mem[raddr];

  // Reference model state
  int               n_checks = 0;
  int               n_fail   = 0;
  logic [DSIZE-1:0] sq[$];       // written, not yet delivered
  int               avail;       // written, not yet read from RAM
  int               held;        // read from RAM, not yet delivered
  int               frame_reads, beat_idx, frames_done, rpos;
  bit               active, done_pending, hold_valid;
  logic [DSIZE-1:0] hold_data;
  logic [ASIZE:0]   wbin;

  function automatic logic [ASIZE:0] gray(input logic [ASIZE:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  task automatic push(input logic [DSIZE-1:0] v);
    mem[wbin[ASIZE-1:0]] = v;
    sq.push_back(v);
    wbin     = wbin + 1'b1;
    avail++;
    rq2_wptr = gray(wbin);
  endtask

  task automatic model_reset();
    wbin = '0; rq2_wptr = '0; sq.delete(); avail = 0; held = 0; rpos = 0;
    active = 0; done_pending = 0; hold_valid = 0; frame_reads = 0; beat_idx = 0;
  endtask

  // One clock cycle: inputs are already set; check the handshake, step the clock.
  task automatic cyc();
    bit               act0, pop;
    logic [DSIZE-1:0] e;
    #1;
    act0 = active;
    pop  = m_valid && m_ready;
    if (hold_valid) begin
      chk("hold_valid", {31'b0, m_valid}, 1);
      chk("hold_data", m_data, hold_data);
    end
    if (!act0 && flush) begin
      sq.delete(); avail = 0; rpos = int'(wbin);
    end else if (!act0 && start) begin
      active = 1; frame_reads = 0; beat_idx = 0;
    end
    if (pop) begin
      if (!act0 || sq.size() == 0) begin
        chk("pop_outside_frame", {31'b0, m_valid}, 0);
      end else begin
        e = sq.pop_front();
        chk("beat_data", m_data, e);
        chk("beat_last", {31'b0, m_last}, {31'b0, beat_idx == FL - 1});
        beat_idx++;
        held--;
        if (beat_idx == FL) begin
          active = 0; done_pending = 1; frames_done++;
        end
      end
    end
    hold_valid = m_valid && !m_ready;
    hold_data  = m_data;
    if (ren) begin
      chk("ren_legal", {31'b0, ren},
          {31'b0, act0 && avail > 0 && frame_reads < FL && held < 2});
      chk("raddr", raddr, rpos % 16);
      avail--; frame_reads++; held++; rpos++;
    end
    @(negedge rclk);
    chk("frame_done", {31'b0, frame_done}, {31'b0, done_pending});
    done_pending = 0;
    chk("busy", {31'b0, busy}, {31'b0, active});
  endtask

  task automatic run_frames(input int target, input int budget);
    while (frames_done < target && budget > 0) begin
      cyc();
      budget--;
    end
    chk("frames_done", frames_done, target);
  endtask

  initial begin
    start = 0; flush = 0; m_ready = 0; frames_done = 0;
    model_reset();
    // Reset with a non-zero write pointer
    rrst_n = 0; rq2_wptr = 5'd5;
    repeat (2) @(negedge rclk);
    #1;
    chk("rst_rptr", rptr, 0);
    chk("rst_rempty", {31'b0, rempty}, 1);
    chk("rst_m_valid", {31'b0, m_valid}, 0);
    chk("rst_busy", {31'b0, busy}, 0);
    chk("rst_ren", {31'b0, ren}, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_frame_done", {31'b0, frame_done}, 0);
    @(negedge rclk);
    rrst_n = 1;
    @(negedge rclk);
    chk("rempty_after_release", {31'b0, rempty}, 0);
    // Reset again with the write domain
    rrst_n = 0; model_reset();
    @(negedge rclk);
    rrst_n = 1;
    @(negedge rclk);

    // Streaming frame
    for (int i = 0; i < FL; i++) push(16'h10 + 16'(i));
    m_ready = 1;
    cyc(); cyc();
    start = 1; cyc(); start = 0;
    #1;
    chk("lat_ren", {31'b0, ren}, 1);
    chk("lat_valid_c1", {31'b0, m_valid}, 0);
    cyc();
    #1;
    chk("lat_valid_c2", {31'b0, m_valid}, 1);
    chk("first_data", m_data, 16'h10);
    run_frames(1, 40);
    chk("rptr_gray8", rptr, 5'h0C);
    chk("rempty_after_frame", {31'b0, rempty}, 1);

    // Backpressure: m_ready toggles every cycle
    for (int i = 0; i < FL; i++) push(16'($urandom));
    start = 1; cyc(); start = 0;
    for (int b = 0; b < 100 && frames_done < 2; b++) begin
      m_ready = ~m_ready;
      cyc();
    end
    chk("bp_frames", frames_done, 2);
    m_ready = 1;

    // Underflow stall: 3 samples, then the rest trickle in
    for (int i = 0; i < 3; i++) push(16'($urandom));
    start = 1; cyc(); start = 0;
    repeat (12) cyc();
    chk("uf_beats", beat_idx, 3);
    chk("uf_rempty", {31'b0, rempty}, 1);
    chk("uf_busy", {31'b0, busy}, 1);
    for (int i = 0; i < 5; i++) begin
      push(16'($urandom));
      cyc();
    end
    run_frames(3, 40);

    // Wrap: four more frames, random writes and random ready
    for (int b = 0; b < 800 && frames_done < 7; b++) begin
      if (sq.size() < 16 && $urandom_range(0, 3) != 0) push(16'($urandom));
      m_ready = ($urandom_range(0, 3) != 0);
      start   = !active && frames_done < 7;
      cyc();
      start = 0;
    end
    chk("wrap_frames", frames_done, 7);
    chk("wrap_rptr", rptr, gray(5'(rpos)));
    m_ready = 1;

    // Flush and start together in IDLE: flush wins
    while (sq.size() < 5) push(16'($urandom));
    flush = 1; start = 1; cyc(); flush = 0; start = 0;
    cyc();
    #1;
    chk("flush_rptr", rptr, rq2_wptr);
    chk("flush_raddr", raddr, wbin[ASIZE-1:0]);
    chk("flush_rempty", {31'b0, rempty}, 1);
    chk("flush_busy", {31'b0, busy}, 0);
    repeat (3) cyc();
    chk("flush_no_valid", {31'b0, m_valid}, 0);

    // start and flush during RUN are ignored
    for (int i = 0; i < FL; i++) push(16'($urandom));
    start = 1; cyc(); start = 0;
    cyc(); cyc();
    for (int i = 0; i < FL; i++) push(16'($urandom));
    start = 1; flush = 1; cyc(); start = 0; flush = 0;
    run_frames(8, 60);
    repeat (5) cyc();
    chk("ign_frames", frames_done, 8);
    chk("ign_no_valid", {31'b0, m_valid}, 0);

    // Reset mid-frame
    start = 1; cyc(); start = 0;
    cyc(); m_ready = 0; cyc(); cyc();
    rrst_n = 0;
    #1;
    chk("mid_rst_rptr", rptr, 0);
    chk("mid_rst_valid", {31'b0, m_valid}, 0);
    chk("mid_rst_busy", {31'b0, busy}, 0);
    chk("mid_rst_rempty", {31'b0, rempty}, 1);
    model_reset();
    @(negedge rclk);
    rrst_n = 1;
    @(negedge rclk);
    for (int i = 0; i < FL; i++) push(16'h100 + 16'(i));
    m_ready = 1;
    cyc();
    start = 1; cyc(); start = 0;
    run_frames(9, 40);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/fifo_rd_frame_ctrl.md
Name: fifo_rd_frame_ctrl

Overview:
Read-domain controller for the audio-sample async FIFO. It owns the read pointer, generates empty from the synchronized Gray write pointer, and sequences FIFO reads into fixed-length frames. Frames are delivered over a valid/ready stream to the FFT front end. The block also supports a discard (flush) of stale samples between frames.

Parameters:
ASIZE, 4, FIFO address width; depth = 2**ASIZE
DSIZE, 16, sample width
FRAME_LEN, 256, samples per frame (>=2, <=65535)

Ports:
rclk  in  1  read clock
rrst_n  in  1  async active-low reset
rq2_wptr  in  ASIZE+1  write pointer, Gray, already synchronized into rclk
rptr  out  ASIZE+1  read pointer, Gray, registered (to write-side synchronizer)
raddr  out  ASIZE  FIFO RAM read address (binary rbin[ASIZE-1:0])
ren  out  1  RAM read enable; rdata valid exactly 1 rclk later
rdata  in  DSIZE  RAM read data
rempty  out  1  FIFO empty, registered
start  in  1  pulse: begin one frame
flush  in  1  pulse: discard all FIFO contents
m_data  out  DSIZE  output sample
m_valid  out  1  output valid
m_ready  in  1  downstream ready
m_last  out  1  marks sample FRAME_LEN-1 of the frame
busy  out  1  high in RUN or DRAIN
frame_done  out  1  1-cycle pulse when last beat is accepted

Behaviour:
- Reset (rrst_n low, async): rbin=0, rptr=0, rempty=1, state=IDLE, counters=0, output buffer empty. m_valid=0, m_last=0, busy=0, frame_done=0, ren=0, m_data=0.
- Pointer: rbinnext = rbin + ren. rgraynext = (rbinnext>>1)^rbinnext. rptr<=rgraynext. rempty<=(rgraynext==rq2_wptr). ren is combinational.
- Wrap-around: rbin is ASIZE+1 bits and wraps naturally; the MSB is the wrap flag. The Gray compare yields full-depth correctness.
- Output buffer: 2-entry FIFO (skid). occ = entries held; infl = 1 if ren was asserted last cycle.
- ren = (state==RUN) && !rempty && (issued < FRAME_LEN) && (occ + infl - pop < 2), where pop = m_valid && m_ready. No read is ever issued without a guaranteed slot.
- Data captured from rdata the cycle after ren. m_data/m_valid come from the head entry. m_last is tagged at capture time for the sample whose index equals FRAME_LEN-1.
- FSM:
  - IDLE: start -> RUN, with issued=0 and sent=0.
  - RUN: on each ren, issued++. When issued reaches FRAME_LEN, go to DRAIN.
  - DRAIN: on pop && m_last, go to IDLE and pulse frame_done the same cycle as the handshake (registered, visible next cycle).
- start while not IDLE: ignored.
- flush is honoured only in IDLE:
  - rbin <= gray2bin(rq2_wptr), rptr <= rq2_wptr, rempty <= 1.
  - flush takes effect the next cycle.
  - start and flush in the same IDLE cycle: flush wins, start is ignored.
  - flush outside IDLE: ignored.
- Empty mid-frame: ren stalls, the FSM stays in RUN, and no timeout applies.
- m_valid must stay high and m_data stable until accepted. Backpressure never loses or duplicates samples.
- Throughput: 1 sample/cycle when the FIFO is non-empty and m_ready=1.
- Latency: start to first m_valid is 2 cycles if the FIFO is non-empty (1 cycle to RUN/ren, then 1 cycle RAM latency).
- Reset mid-frame: immediate return to reset state. In-flight data is discarded and the pointer returns to 0. The write domain must be reset together.

Test Plan:
- Reset: hold rrst_n=0 with rq2_wptr=5 -> rptr=0, rempty=1, m_valid=0, busy=0. After release, rempty goes to 0 within 1 cycle.
- Streaming frame: FRAME_LEN=8, preload 8 samples 0x10..0x17, m_ready=1, pulse start -> m_valid on cycles 2..9 with data 0x10..0x17 and m_last only on 0x17; frame_done pulse; rptr=Gray(8)=0x0C.
- Backpressure: same preload, toggle m_ready 1/0 every cycle -> sequence is exact, no drops or duplicates, and ren never fires with occ+infl=2.
- Underflow stall: FRAME_LEN=8, only 3 samples present -> 3 beats, then rempty=1 and busy=1. Write 5 more -> frame completes with m_last on the 8th beat.
- Wrap: ASIZE=4, run 3 frames of FRAME_LEN=12 through a depth-16 FIFO -> all 36 samples in order; rbin crosses 16 and rempty stays correct.
- Flush and ignored commands: in IDLE, rq2_wptr=Gray(9), pulse flush+start together -> rbin=9, rempty=1, state stays IDLE. A start issued during RUN is ignored (frame count unchanged).
